// File: rtl/timing_stats_mc_if.sv
// timing_stats_mc_if: sample, clear and read port bundle for timing_stats_mc
interface timing_stats_mc_if #(
  parameter int P_WIDTH     = 32,
  parameter int P_CHANNELS  = 4,
  parameter int P_CNT_WIDTH = 16,
  parameter int P_SUM_WIDTH = 48
);
  localparam int CH_W = P_CHANNELS > 1 ? $clog2(P_CHANNELS) : 1;
  logic                   io_fbCatchIn;
  logic [CH_W-1:0]        io_chIn;
  logic [P_WIDTH-1:0]     io_timingIn;
  logic                   io_clrReq;
  logic                   io_clrAll;
  logic [CH_W-1:0]        io_clrCh;
  logic                   io_rdReq;
  logic [CH_W-1:0]        io_rdCh;
  logic                   io_rdValid;
  logic                   io_rdSeen;
  logic                   io_rdOvf;
  logic [P_WIDTH-1:0]     io_timing1st;
  logic [P_WIDTH-1:0]     io_timingMax;
  logic [P_WIDTH-1:0]     io_timingMin;
  logic [P_CNT_WIDTH-1:0] io_count;
  logic [P_SUM_WIDTH-1:0] io_sum;
  modport master (
    output io_fbCatchIn, io_chIn, io_timingIn, io_clrReq, io_clrAll, io_clrCh, io_rdReq, io_rdCh,
    input  io_rdValid, io_rdSeen, io_rdOvf, io_timing1st, io_timingMax, io_timingMin, io_count, io_sum
  );
  modport slave (
    input  io_fbCatchIn, io_chIn, io_timingIn, io_clrReq, io_clrAll, io_clrCh, io_rdReq, io_rdCh,
    output io_rdValid, io_rdSeen, io_rdOvf, io_timing1st, io_timingMax, io_timingMin, io_count, io_sum
  );
endinterface

// File: rtl/timing_stats_mc.sv
// timing_stats_mc: per-channel first/max/min/count/sum statistics with saturating
// count and sum, sticky overflow, per-channel or global clear and 1-cycle reads
module timing_stats_mc #(
  parameter int P_WIDTH     = 32,
  parameter int P_CHANNELS  = 4,
  parameter int P_CNT_WIDTH = 16,
  parameter int P_SUM_WIDTH = 48
) (
  input logic               io_clk,
  input logic               io_rstN,
  timing_stats_mc_if.slave  bus
);
  logic                   seen  [P_CHANNELS];
  logic                   ovf   [P_CHANNELS];
  logic [P_WIDTH-1:0]     first [P_CHANNELS];
  logic [P_WIDTH-1:0]     mx    [P_CHANNELS];
  logic [P_WIDTH-1:0]     mn    [P_CHANNELS];
  logic [P_CNT_WIDTH-1:0] cnt   [P_CHANNELS];
  logic [P_SUM_WIDTH-1:0] sum   [P_CHANNELS];
  logic [P_SUM_WIDTH:0]   add   [P_CHANNELS];
  logic                   rd_in;
  // one extra bit catches the carry that means the sum would saturate
  always_comb begin
    for (int c = 0; c < P_CHANNELS; c++)
      add[c] = {1'b0, sum[c]} + {{(P_SUM_WIDTH + 1 - P_WIDTH){1'b0}}, bus.io_timingIn};
    rd_in = int'(bus.io_rdCh) < P_CHANNELS;
  end
  always_ff @(posedge io_clk or negedge io_rstN) begin
    if (!io_rstN) begin
      for (int c = 0; c < P_CHANNELS; c++) begin
        seen[c]  <= 1'b0;
        ovf[c]   <= 1'b0;
        first[c] <= '0;
        mx[c]    <= '0;
        mn[c]    <= '1;
        cnt[c]   <= '0;
        sum[c]   <= '0;
      end
      bus.io_rdValid   <= 1'b0;
      bus.io_rdSeen    <= 1'b0;
      bus.io_rdOvf     <= 1'b0;
      bus.io_timing1st <= '0;
      bus.io_timingMax <= '0;
      bus.io_timingMin <= '1;
      bus.io_count     <= '0;
      bus.io_sum       <= '0;
    end else begin
      for (int c = 0; c < P_CHANNELS; c++) begin
        if (bus.io_clrReq && (bus.io_clrAll || int'(bus.io_clrCh) == c)) begin
          seen[c]  <= 1'b0;
          ovf[c]   <= 1'b0;
          first[c] <= '0;
          mx[c]    <= '0;
          mn[c]    <= '1;
          cnt[c]   <= '0;
          sum[c]   <= '0;
        end else if (bus.io_fbCatchIn && int'(bus.io_chIn) == c) begin
          if (!seen[c]) begin
            seen[c]  <= 1'b1;
            first[c] <= bus.io_timingIn;
          end
          if (bus.io_timingIn > mx[c]) mx[c] <= bus.io_timingIn;
          if (bus.io_timingIn < mn[c]) mn[c] <= bus.io_timingIn;
          if (&cnt[c]) ovf[c] <= 1'b1;
          else begin
            cnt[c] <= cnt[c] + 1'b1;
            sum[c] <= add[c][P_SUM_WIDTH] ? '1 : add[c][P_SUM_WIDTH-1:0];
            if (add[c][P_SUM_WIDTH]) ovf[c] <= 1'b1;
          end
        end
      end
      bus.io_rdValid <= bus.io_rdReq;
      if (bus.io_rdReq) begin
        bus.io_rdSeen    <= rd_in ? seen[bus.io_rdCh]  : 1'b0;
        bus.io_rdOvf     <= rd_in ? ovf[bus.io_rdCh]   : 1'b0;
        bus.io_timing1st <= rd_in ? first[bus.io_rdCh] : '0;
        bus.io_timingMax <= rd_in ? mx[bus.io_rdCh]    : '0;
        bus.io_timingMin <= rd_in ? mn[bus.io_rdCh]    : '1;
        bus.io_count     <= rd_in ? cnt[bus.io_rdCh]   : '0;
        bus.io_sum       <= rd_in ? sum[bus.io_rdCh]   : '0;
      end
    end
  end
endmodule

// File: tb/tb_timing_stats_mc.sv
// tb_timing_stats_mc: directed checks of timing_stats_mc with small widths so that
// count and sum saturation are reachable in a few cycles
module tb_timing_stats_mc;
  localparam int W = 8, N = 5, CW = 4, SW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0;
  timing_stats_mc_if #(.P_WIDTH(W), .P_CHANNELS(N), .P_CNT_WIDTH(CW), .P_SUM_WIDTH(SW)) bus ();
  timing_stats_mc #(.P_WIDTH(W), .P_CHANNELS(N), .P_CNT_WIDTH(CW), .P_SUM_WIDTH(SW)) dut (
    .io_clk(clk), .io_rstN(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    bus.io_fbCatchIn = 0; bus.io_chIn = 0; bus.io_timingIn = 0;
    bus.io_clrReq = 0; bus.io_clrAll = 0; bus.io_clrCh = 0;
    bus.io_rdReq = 0; bus.io_rdCh = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1 idle();
  endtask
  task automatic smp(input int ch, input int v);
    bus.io_fbCatchIn = 1; bus.io_chIn = 3'(ch); bus.io_timingIn = 8'(v);
    step();
  endtask
  task automatic rd(input int ch);
    bus.io_rdReq = 1; bus.io_rdCh = 3'(ch);
    step();
  endtask
  task automatic expect_stats(input string tag, input int sn, input int of, input int f,
                              input int mx, input int mn, input int c, input int s);
    check({tag, ".valid"}, bus.io_rdValid, 1);
    check({tag, ".seen"}, bus.io_rdSeen, sn[0]);
    check({tag, ".ovf"}, bus.io_rdOvf, of[0]);
    check({tag, ".1st"}, bus.io_timing1st, f[7:0]);
    check({tag, ".max"}, bus.io_timingMax, mx[7:0]);
    check({tag, ".min"}, bus.io_timingMin, mn[7:0]);
    check({tag, ".count"}, bus.io_count, c[3:0]);
    check({tag, ".sum"}, bus.io_sum, s[7:0]);
  endtask
  initial begin
    idle();
    #12;
    check("rst.valid", bus.io_rdValid, 0);
    check("rst.min", bus.io_timingMin, 8'hFF);
    check("rst.count", bus.io_count, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    smp(2, 7); smp(2, 0); smp(2, 12);
    rd(2); expect_stats("ch2", 1, 0, 7, 12, 0, 3, 19);
    step();
    check("hold.valid", bus.io_rdValid, 0);
    check("hold.count", bus.io_count, 3);
    rd(0); expect_stats("ch0_empty", 0, 0, 0, 0, 255, 0, 0);
    rd(3); expect_stats("ch3_empty", 0, 0, 0, 0, 255, 0, 0);
    smp(0, 0); smp(0, 5);
    rd(0); expect_stats("ch0_zero1st", 1, 0, 0, 5, 0, 2, 5);
    for (int i = 0; i < 17; i++) smp(1, 1);
    rd(1); expect_stats("ch1_cntovf", 1, 1, 1, 1, 1, 15, 15);
    bus.io_clrReq = 1; bus.io_clrCh = 1; step();
    rd(1); expect_stats("ch1_clr", 0, 0, 0, 0, 255, 0, 0);
    smp(4, 200); smp(4, 100);
    rd(4); expect_stats("ch4_sumsat", 1, 1, 200, 200, 100, 2, 255);
    smp(4, 250); smp(4, 2);
    rd(4); expect_stats("ch4_postovf", 1, 1, 200, 250, 2, 4, 255);
    bus.io_clrReq = 1; bus.io_clrAll = 1; bus.io_clrCh = 2; step();
    rd(4); expect_stats("clrall_ch4", 0, 0, 0, 0, 255, 0, 0);
    smp(3, 50);
    bus.io_clrReq = 1; bus.io_clrCh = 3; bus.io_fbCatchIn = 1; bus.io_chIn = 3; bus.io_timingIn = 9; step();
    bus.io_clrReq = 1; bus.io_clrCh = 3; bus.io_fbCatchIn = 1; bus.io_chIn = 0; bus.io_timingIn = 4; step();
    rd(3); expect_stats("ch3_clrwin", 0, 0, 0, 0, 255, 0, 0);
    rd(0); expect_stats("ch0_beside", 1, 0, 4, 4, 4, 1, 4);
    bus.io_fbCatchIn = 1; bus.io_chIn = 1; bus.io_timingIn = 20;
    bus.io_rdReq = 1; bus.io_rdCh = 1; step();
    expect_stats("ch1_pre", 0, 0, 0, 0, 255, 0, 0);
    rd(1); expect_stats("ch1_post", 1, 0, 20, 20, 20, 1, 20);
    bus.io_clrReq = 1; bus.io_clrCh = 1; bus.io_rdReq = 1; bus.io_rdCh = 1; step();
    expect_stats("ch1_clr_pre", 1, 0, 20, 20, 20, 1, 20);
    smp(6, 99);
    rd(6); expect_stats("oor_rd", 0, 0, 0, 0, 255, 0, 0);
    rd(0); expect_stats("oor_ignored", 1, 0, 4, 4, 4, 1, 4);
    smp(1, 8); smp(2, 3);
    rd(2); expect_stats("ch2_pre_rst", 1, 0, 3, 3, 3, 1, 3);
    bus.io_fbCatchIn = 1; bus.io_chIn = 2; bus.io_timingIn = 77; bus.io_rdReq = 1; bus.io_rdCh = 0;
    #2 rst_n = 0;
    #1;
    check("arst.valid", bus.io_rdValid, 0);
    check("arst.seen", bus.io_rdSeen, 0);
    check("arst.min", bus.io_timingMin, 8'hFF);
    check("arst.count", bus.io_count, 0);
    check("arst.sum", bus.io_sum, 0);
    check("arst.1st", bus.io_timing1st, 0);
    @(posedge clk); #1 idle();
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      rd(c); expect_stats($sformatf("post_rst_ch%0d", c), 0, 0, 0, 0, 255, 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/timing_stats_mc.md
TIMING_STATS_MC -- requirements
Module: timing_stats_mc

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- P_WIDTH, 32, sample width in bits.
- P_CHANNELS, 4, number of independent statistic channels, range 1..16.
- P_CNT_WIDTH, 16, per-channel sample-count width.
- P_SUM_WIDTH, 48, per-channel accumulator width, at least P_WIDTH.
- CH_W (derived), max(1, clog2(P_CHANNELS)), channel-index width.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- io_clk, in, 1, single clock, rising edge.
- io_rstN, in, 1, reset, asynchronous assert, active-low.
- io_fbCatchIn, in, 1, sample strobe.
- io_chIn, in, CH_W, channel of the current sample.
- io_timingIn, in, P_WIDTH, sample value.
- io_clrReq, in, 1, clear strobe.
- io_clrAll, in, 1, with io_clrReq: clear every channel.
- io_clrCh, in, CH_W, channel to clear when io_clrAll=0.
- io_rdReq, in, 1, read strobe.
- io_rdCh, in, CH_W, channel to read.
- io_rdValid, out, 1, read data valid, one-cycle pulse.
- io_rdSeen, out, 1, channel has at least one sample.
- io_rdOvf, out, 1, channel sticky overflow.
- io_timing1st, out, P_WIDTH, first sample since clear.
- io_timingMax, out, P_WIDTH, maximum sample.
- io_timingMin, out, P_WIDTH, minimum sample.
- io_count, out, P_CNT_WIDTH, accepted sample count.
- io_sum, out, P_SUM_WIDTH, sum of counted samples.

REQ-003 The block SHALL use the single clock io_clk; reset io_rstN SHALL be asynchronous and active-low.

Function
REQ-004 Each channel SHALL hold: seen, 1st, max, min, count, sum, ovf.
REQ-005 A channel's empty state SHALL be: seen=0, 1st=0, max=0, min=all-ones (P_WIDTH), count=0, sum=0, ovf=0.
REQ-006 A sample SHALL be accepted when io_fbCatchIn=1 and io_chIn<P_CHANNELS; an out-of-range io_chIn SHALL be ignored with no state change.
REQ-007 An accepted sample SHALL update only channel io_chIn, on the next rising edge.
REQ-008 On an accepted sample with seen=0, the block SHALL set 1st=sample and seen=1. The first sample SHALL be tracked by seen, not by a nonzero test, so a sample value of 0 is a valid first sample.
REQ-009 On an accepted sample, max SHALL be set to the sample when sample>max (unsigned), and min to the sample when sample<min (unsigned).
REQ-010 On an accepted sample with count<all-ones, count SHALL increment by 1. With count=all-ones, count and sum SHALL hold and ovf SHALL set.
REQ-011 sum SHALL add the zero-extended sample when count increments. If the addition would exceed all-ones (P_SUM_WIDTH), sum SHALL saturate at all-ones and ovf SHALL set.
REQ-012 ovf SHALL be sticky until that channel is cleared or reset.
REQ-013 Min and max SHALL keep updating after overflow.
REQ-014 io_clrReq=1 SHALL return the target channel to the empty state on the next edge. The target is every channel when io_clrAll=1, else io_clrCh; an out-of-range io_clrCh SHALL be ignored.
REQ-015 Clear SHALL take priority over a sample in the same cycle to a cleared channel. That sample SHALL be discarded.
REQ-016 A sample to a channel not being cleared SHALL proceed normally in the same cycle.
REQ-017 io_rdReq=1 SHALL capture channel io_rdCh into the output registers on the next edge, with io_rdValid=1 for exactly that cycle.
REQ-018 Read latency SHALL be 1 cycle; back-to-back reads SHALL be accepted every cycle.
REQ-019 A read SHALL return pre-edge state: a sample or clear to the same channel in the same cycle SHALL NOT be visible in that read.
REQ-020 A read with out-of-range io_rdCh SHALL return the empty-state values with io_rdValid=1.
REQ-021 Output registers SHALL hold their last captured values while io_rdReq=0.

Reset
REQ-022 Asserting io_rstN=0 SHALL immediately put every channel in the empty state.
REQ-023 Asserting io_rstN=0 SHALL immediately set io_rdValid=0, and set output registers to the empty-state values (io_timingMin=all-ones).
REQ-024 A sample, clear or read pending when reset asserts SHALL be lost. The first accepted operation SHALL be on the first rising edge after io_rstN deasserts.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Ch2 samples 7, 0, 12, then read ch2 -> 1st=7, max=12, min=0, count=3, sum=19, seen=1, ovf=0; other channels empty.
- Ch0 first sample 0, then 5 -> 1st=0 (not 5), seen=1.
- P_CNT_WIDTH=4, 17 samples of 1 to ch1 -> count=15, sum=15, ovf=1, max/min=1. Then clear ch1 -> empty state.
- Same-cycle clear ch3 and sample ch3=9, plus sample on ch0=4 with clrAll=0 -> ch3 empty, ch0 count=1.
- Sample ch1=20 and read ch1 in the same cycle -> read shows pre-update values; next read shows max=20.
- Assert io_rstN mid-stream with 3 channels populated -> all outputs empty immediately, io_rdValid=0; read of any channel after release -> empty state.
